// File: rtl/riscv_pkg.sv
// Shared constants for the ID/EX pipeline stage: control bundle width,
// the hard-wired zero register index and the control bundle field layout.
package riscv_pkg;

    // Width of the opaque EX/MEM control bundle carried through ID/EX.
    localparam int CTRL_W = 12;

    // Index of the hard-wired zero register.
    localparam logic [4:0] X0_ADDR = 5'd0;

    // Field offsets inside the control bundle. The stage itself treats the
    // bundle as opaque; these are here so EX/MEM decode from one place.
    localparam int CTRL_ALU_OP_LSB      = 0;
    localparam int CTRL_ALU_OP_W        = 4;
    localparam int CTRL_ALU_SRC_BIT     = 4;
    localparam int CTRL_BRANCH_BIT      = 5;
    localparam int CTRL_JUMP_BIT        = 6;
    localparam int CTRL_MEM_WRITE_BIT   = 7;
    localparam int CTRL_MEM_SIZE_LSB    = 8;
    localparam int CTRL_MEM_SIZE_W      = 2;
    localparam int CTRL_MEM_UNSIGNED_BIT = 10;
    localparam int CTRL_WB_SEL_BIT      = 11;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection for the ID/EX stage. Purely combinational:
// flags a hazard when the instruction in EX is a load whose destination is
// read by the valid instruction in ID, and requests an IF/ID stall unless a
// flush kills the ID instruction or reset is active.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic       rst,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd_addr,
    input  logic       id_valid,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       ex_flush,
    output logic       haz,
    output logic       stall_if_id
);

    logic rs1_match_s;
    logic rs2_match_s;

    // Compare ID source registers against the load destination held in EX.
    always_comb begin
        rs1_match_s = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
        rs2_match_s = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
        haz         = ex_valid & ex_mem_read & (ex_rd_addr != X0_ADDR) &
                      id_valid & (rs1_match_s | rs2_match_s);
        // A flushed instruction is dead, so holding IF/ID for it is pointless.
        stall_if_id = haz & ~ex_flush & ~rst;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB-to-ID operand bypass, load-use bubble
// insertion, branch flush and saturating bubble/flush counters.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = riscv_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [WIDTH-1:0]  id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        id_rd_addr,
    input  logic [WIDTH-1:0]  id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [WIDTH-1:0]  rs1_data,
    input  logic [WIDTH-1:0]  rs2_data,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd_addr,
    input  logic [WIDTH-1:0]  wb_write_data,
    input  logic              ex_flush,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [WIDTH-1:0]  ex_pc,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd_addr,
    output logic [WIDTH-1:0]  ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [WIDTH-1:0]  ex_rs1_data,
    output logic [WIDTH-1:0]  ex_rs2_data,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic             haz_s;
    logic [WIDTH-1:0] op1_s;
    logic [WIDTH-1:0] op2_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    hazard_detect u_hazard_detect (
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd_addr  (ex_rd_addr),
        .id_valid    (id_valid),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .ex_flush    (ex_flush),
        .haz         (haz_s),
        .stall_if_id (stall_if_id)
    );

    // WB-to-ID bypass: x0 reads zero, a same-cycle WB write wins over the
    // register file, which still holds the old value this cycle.
    always_comb begin
        op1_s = '0;
        op2_s = '0;
        if (id_rs1_addr == X0_ADDR) begin
            op1_s = '0;
        end else if (wb_reg_write && (wb_rd_addr == id_rs1_addr)) begin
            op1_s = wb_write_data;
        end else begin
            op1_s = rs1_data;
        end
        if (id_rs2_addr == X0_ADDR) begin
            op2_s = '0;
        end else if (wb_reg_write && (wb_rd_addr == id_rs2_addr)) begin
            op2_s = wb_write_data;
        end else begin
            op2_s = rs2_data;
        end
    end

    // Pipeline register and counters: reset, then flush, then hazard bubble,
    // then normal capture (an empty ID slot becomes a bubble).
    always_ff @(posedge clk) begin
        if (rst || ex_flush || haz_s || !id_valid) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_addr  <= 5'd0;
            ex_rs2_addr  <= 5'd0;
            ex_rd_addr   <= 5'd0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1_addr  <= id_rs1_addr;
            ex_rs2_addr  <= id_rs2_addr;
            ex_rd_addr   <= id_rd_addr;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_ctrl;
            ex_mem_read  <= id_mem_read;
            ex_reg_write <= id_reg_write;
            ex_rs1_data  <= op1_s;
            ex_rs2_data  <= op2_s;
        end

        if (rst) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (ex_flush) begin
            bubble_count <= bubble_count;
            flush_count  <= sat_inc(flush_count);
        end else if (haz_s) begin
            bubble_count <= sat_inc(bubble_count);
            flush_count  <= flush_count;
        end else begin
            bubble_count <= bubble_count;
            flush_count  <= flush_count;
        end
    end

endmodule
